clint_bus_arbiter: RTL and testbench

- Shares the single CLINT register-bus slave port between two requesters.
  - m0: the core load/store path.
  - m1: the debug/system master.
- Round-robin arbitration and a fixed 3-cycle access sequence: latch, strobe, respond.
- Optional lock, so a requester can perform back-to-back 32-bit halves of mtime/mtimecmp without interleaving.
- Sits between the requesters and the CLINT's bus_clint_* / clint_bus_data interface.

---
 rtl/clint_pkg.sv | 31 +++
 rtl/rr_arbiter2.sv | 28 ++
 rtl/clint_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_clint_bus_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared types and constants for the CLINT register-bus arbiter.
//   arb_state_t : arbiter FSM state encoding
//   bus_req_t   : latched request fields of the winning master
//   CLINT_*     : register addresses used by software and the bench
package clint_pkg;

  localparam int unsigned ADDR_WIDTH     = 16;
  localparam int unsigned SIZE_WIDTH     = 3;
  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned BUS_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                      rd;
    logic                      wr;
    logic                      lock;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [SIZE_WIDTH-1:0]     size;
    logic [REG_DATA_WIDTH-1:0] wdata;
  } bus_req_t;

  localparam logic [ADDR_WIDTH-1:0] CLINT_MSIP_ADDR     = 16'h0000;
  localparam logic [ADDR_WIDTH-1:0] CLINT_MTIMECMP_ADDR = 16'h4000;
  localparam logic [ADDR_WIDTH-1:0] CLINT_MTIME_ADDR    = 16'hbff8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with an eligibility mask.
//   req           : raw requests from m0/m1
//   eligible      : mask of masters allowed to win (lock restricts to owner)
//   rr_ptr        : master that wins a tie
//   grant_valid_c : some eligible master is requesting
//   grant_idx_c   : index of the winning master
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic [1:0] eligible,
  input  logic       rr_ptr,
  output logic       grant_valid_c,
  output logic       grant_idx_c
);

  logic [1:0] cand;

  always_comb begin
    cand          = req & eligible;
    grant_valid_c = |cand;
    grant_idx_c   = 1'b0;
    case (cand)
      2'b10:   grant_idx_c = 1'b1;
      2'b11:   grant_idx_c = rr_ptr;
      default: grant_idx_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/clint_bus_arbiter.sv
// Shares the CLINT register-bus slave port between m0 (core) and m1 (debug).
// Each access runs IDLE(arbitrate/latch) -> ACCESS(strobe) -> RESP(ack).
// A master may lock the bus so paired 32-bit halves are not interleaved.
//   clk, rst            : clock, asynchronous active-low reset
//   mN_*                : requester ports (req/rd/wr/lock/addr/size/wdata, ack/rdata)
//   bus_clint_*         : registered address/size/data/strobes to the CLINT
//   clint_bus_data      : combinational read data from the CLINT
//   busy                : arbiter is not in IDLE
module clint_bus_arbiter
  import clint_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_WIDTH,
  parameter int unsigned SIZE_W       = SIZE_WIDTH,
  parameter int unsigned DATA_W       = REG_DATA_WIDTH,
  parameter int unsigned RDATA_W      = BUS_DATA_WIDTH,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_req,
  input  logic               m0_rd,
  input  logic               m0_wr,
  input  logic               m0_lock,
  input  logic [ADDR_W-1:0]  m0_addr,
  input  logic [SIZE_W-1:0]  m0_size,
  input  logic [DATA_W-1:0]  m0_wdata,
  output logic               m0_ack,
  output logic [RDATA_W-1:0] m0_rdata,
  input  logic               m1_req,
  input  logic               m1_rd,
  input  logic               m1_wr,
  input  logic               m1_lock,
  input  logic [ADDR_W-1:0]  m1_addr,
  input  logic [SIZE_W-1:0]  m1_size,
  input  logic [DATA_W-1:0]  m1_wdata,
  output logic               m1_ack,
  output logic [RDATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0]  bus_clint_read_addr,
  output logic [ADDR_W-1:0]  bus_clint_write_addr,
  output logic [SIZE_W-1:0]  bus_clint_read_size,
  output logic [SIZE_W-1:0]  bus_clint_write_size,
  output logic [DATA_W-1:0]  bus_clint_data,
  output logic               bus_clint_rd,
  output logic               bus_clint_wr,
  input  logic [RDATA_W-1:0] clint_bus_data,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE   = 2'(ARB_IDLE);
  localparam logic [1:0] S_ACCESS = 2'(ARB_ACCESS);
  localparam logic [1:0] S_RESP   = 2'(ARB_RESP);

  logic [1:0]         state_q, state_d;
  bus_req_t           req_q, cand_c;
  logic               winner_q, rr_ptr_q;
  logic               lock_valid_q, lock_owner_q;
  logic [CNT_W-1:0]   lock_cnt_q;
  logic               bus_rd_q, bus_wr_q, busy_q;
  logic [1:0]         ack_q;
  logic [RDATA_W-1:0] rdata0_q, rdata1_q;
  logic [1:0]         req_vec_c, eligible_c;
  logic               grant_valid_c, grant_idx_c;

  // A lock restricts eligibility to its owner until released or timed out.
  assign req_vec_c  = {m1_req, m0_req};
  assign eligible_c = lock_valid_q ? (lock_owner_q ? 2'b10 : 2'b01) : 2'b11;

  rr_arbiter2 u_rr (
    .req           (req_vec_c),
    .eligible      (eligible_c),
    .rr_ptr        (rr_ptr_q),
    .grant_valid_c (grant_valid_c),
    .grant_idx_c   (grant_idx_c)
  );

  // Request fields of the current arbitration winner.
  always_comb begin
    cand_c = '0;
    if (grant_idx_c) begin
      cand_c.rd    = m1_rd;
      cand_c.wr    = m1_wr;
      cand_c.lock  = m1_lock;
      cand_c.addr  = ADDR_WIDTH'(m1_addr);
      cand_c.size  = SIZE_WIDTH'(m1_size);
      cand_c.wdata = REG_DATA_WIDTH'(m1_wdata);
    end else begin
      cand_c.rd    = m0_rd;
      cand_c.wr    = m0_wr;
      cand_c.lock  = m0_lock;
      cand_c.addr  = ADDR_WIDTH'(m0_addr);
      cand_c.size  = SIZE_WIDTH'(m0_size);
      cand_c.wdata = REG_DATA_WIDTH'(m0_wdata);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_valid_c) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath, strobes, ack/rdata, round-robin pointer and lock tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q        <= '0;
      winner_q     <= 1'b0;
      rr_ptr_q     <= 1'b0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= '0;
      bus_rd_q     <= 1'b0;
      bus_wr_q     <= 1'b0;
      busy_q       <= 1'b0;
      ack_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      bus_rd_q <= 1'b0;
      bus_wr_q <= 1'b0;
      ack_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= (state_d != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (grant_valid_c) begin
            req_q    <= cand_c;
            winner_q <= grant_idx_c;
            // rd together with wr is treated as a write.
            bus_wr_q <= cand_c.wr;
            bus_rd_q <= cand_c.rd & ~cand_c.wr;
          end else if (lock_valid_q && !req_vec_c[lock_owner_q]) begin
            if (lock_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
              lock_valid_q <= 1'b0;
              lock_cnt_q   <= '0;
            end else begin
              lock_cnt_q <= lock_cnt_q + CNT_W'(1);
            end
          end
        end
        S_ACCESS: begin
          if (winner_q) begin
            ack_q    <= 2'b10;
            rdata1_q <= (req_q.rd & ~req_q.wr) ? clint_bus_data : '0;
          end else begin
            ack_q    <= 2'b01;
            rdata0_q <= (req_q.rd & ~req_q.wr) ? clint_bus_data : '0;
          end
        end
        S_RESP: begin
          rr_ptr_q     <= ~winner_q;
          lock_valid_q <= req_q.lock;
          if (req_q.lock) begin
            lock_owner_q <= winner_q;
            lock_cnt_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign m0_ack               = ack_q[0];
  assign m1_ack               = ack_q[1];
  assign m0_rdata             = rdata0_q;
  assign m1_rdata             = rdata1_q;
  assign bus_clint_read_addr  = ADDR_W'(req_q.addr);
  assign bus_clint_write_addr = ADDR_W'(req_q.addr);
  assign bus_clint_read_size  = SIZE_W'(req_q.size);
  assign bus_clint_write_size = SIZE_W'(req_q.size);
  assign bus_clint_data       = DATA_W'(req_q.wdata);
  assign bus_clint_rd         = bus_rd_q;
  assign bus_clint_wr         = bus_wr_q;
  assign busy                 = busy_q;

endmodule

// File: tb/tb_clint_bus_arbiter.sv
// Directed self-checking bench for clint_bus_arbiter.
module tb_clint_bus_arbiter;
  import clint_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_rd, m0_wr, m0_lock;
  logic [15:0] m0_addr;
  logic [2:0]  m0_size;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_rd, m1_wr, m1_lock;
  logic [15:0] m1_addr;
  logic [2:0]  m1_size;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic [15:0] bus_clint_read_addr, bus_clint_write_addr;
  logic [2:0]  bus_clint_read_size, bus_clint_write_size;
  logic [31:0] bus_clint_data;
  logic        bus_clint_rd, bus_clint_wr;
  logic [31:0] clint_bus_data;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clint_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_size(m0_size), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_size(m1_size), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_clint_read_addr(bus_clint_read_addr), .bus_clint_write_addr(bus_clint_write_addr),
    .bus_clint_read_size(bus_clint_read_size), .bus_clint_write_size(bus_clint_write_size),
    .bus_clint_data(bus_clint_data), .bus_clint_rd(bus_clint_rd), .bus_clint_wr(bus_clint_wr),
    .clint_bus_data(clint_bus_data), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_rd = 0; m0_wr = 0; m0_lock = 0; m0_addr = '0; m0_size = 3'd2; m0_wdata = '0;
    m1_req = 0; m1_rd = 0; m1_wr = 0; m1_lock = 0; m1_addr = '0; m1_size = 3'd2; m1_wdata = '0;
    clint_bus_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if ({bus_clint_rd, bus_clint_wr, m0_ack, m1_ack} !== 4'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {bus_clint_rd, bus_clint_wr, m0_ack, m1_ack}); end
    checks++; if ({bus_clint_read_addr, bus_clint_data, m0_rdata, m1_rdata} !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", {bus_clint_read_addr, bus_clint_data, m0_rdata, m1_rdata}); end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_rd = 1; m0_addr = CLINT_MTIMECMP_ADDR; clint_bus_data = 32'h12345678;
    tick(); // cycle 2
    checks++; if ({bus_clint_rd, bus_clint_wr, busy, m0_ack} !== 4'b1010) begin failures++; $display("FAIL rd_c2 got=%b exp=1010", {bus_clint_rd, bus_clint_wr, busy, m0_ack}); end
    checks++; if (bus_clint_read_addr !== 16'h4000 || bus_clint_read_size !== 3'd2) begin failures++; $display("FAIL rd_addr got=%h/%0d exp=4000/2", bus_clint_read_addr, bus_clint_read_size); end
    tick(); // cycle 3
    checks++; if ({bus_clint_rd, busy, m0_ack, m1_ack} !== 4'b0110) begin failures++; $display("FAIL rd_c3 got=%b exp=0110", {bus_clint_rd, busy, m0_ack, m1_ack}); end
    checks++; if (m0_rdata !== 32'h12345678) begin failures++; $display("FAIL rd_rdata got=%h exp=12345678", m0_rdata); end
    m0_req = 0;
    tick(); // cycle 4
    checks++; if ({busy, m0_ack} !== 2'b00 || m0_rdata !== 32'h0) begin failures++; $display("FAIL rd_c4 got=%b/%h exp=00/0", {busy, m0_ack}, m0_rdata); end
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_req = 1; m0_wr = 1; m0_addr = 16'h0000; m0_wdata = 32'hAAAA0000;
    m1_req = 1; m1_wr = 1; m1_addr = 16'h0004; m1_wdata = 32'hBBBB0001;
    tick(); // cycle 2: m0 strobes
    checks++; if (bus_clint_wr !== 1'b1 || bus_clint_data !== 32'hAAAA0000 || bus_clint_write_addr !== 16'h0000) begin failures++; $display("FAIL rr_first got=%0h/%h/%h exp=1/aaaa0000/0000", bus_clint_wr, bus_clint_data, bus_clint_write_addr); end
    tick(); // cycle 3: m0 ack, m0 re-requests
    checks++; if ({m0_ack, m1_ack} !== 2'b10) begin failures++; $display("FAIL rr_ack0 got=%b exp=10", {m0_ack, m1_ack}); end
    m0_wdata = 32'hCCCC0002;
    tick(); // cycle 4: IDLE, tie goes to m1
    checks++; if ({busy, bus_clint_wr} !== 2'b00) begin failures++; $display("FAIL rr_idle got=%b exp=00", {busy, bus_clint_wr}); end
    tick(); // cycle 5
    checks++; if (bus_clint_wr !== 1'b1 || bus_clint_data !== 32'hBBBB0001 || bus_clint_write_addr !== 16'h0004) begin failures++; $display("FAIL rr_second got=%0h/%h/%h exp=1/bbbb0001/0004", bus_clint_wr, bus_clint_data, bus_clint_write_addr); end
    tick(); // cycle 6
    checks++; if ({m0_ack, m1_ack} !== 2'b01 || m1_rdata !== 32'h0) begin failures++; $display("FAIL rr_ack1 got=%b/%h exp=01/0", {m0_ack, m1_ack}, m1_rdata); end
    m1_req = 0;
    tick(); tick(); // cycle 8: m0 served
    checks++; if (bus_clint_wr !== 1'b1 || bus_clint_data !== 32'hCCCC0002) begin failures++; $display("FAIL rr_third got=%0h/%h exp=1/cccc0002", bus_clint_wr, bus_clint_data); end
    tick();
    checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL rr_ack0b got=%0h exp=1", m0_ack); end
    m0_req = 0;
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    m1_req = 1; m1_wr = 1; m1_lock = 1; m1_addr = CLINT_MTIME_ADDR; m1_wdata = 32'h0000_1111;
    tick(); // cycle 2
    checks++; if (bus_clint_wr !== 1'b1 || bus_clint_write_addr !== 16'hbff8) begin failures++; $display("FAIL lock_w1 got=%0h/%h exp=1/bff8", bus_clint_wr, bus_clint_write_addr); end
    m0_req = 1; m0_wr = 1; m0_addr = 16'h0000; m0_wdata = 32'h5;
    tick(); // cycle 3
    checks++; if (m1_ack !== 1'b1) begin failures++; $display("FAIL lock_ack1 got=%0h exp=1", m1_ack); end
    m1_lock = 0; m1_addr = 16'hbffc; m1_wdata = 32'h0000_2222;
    tick(); // cycle 4
    tick(); // cycle 5: still m1
    checks++; if (bus_clint_wr !== 1'b1 || bus_clint_write_addr !== 16'hbffc || bus_clint_data !== 32'h2222) begin failures++; $display("FAIL lock_w2 got=%0h/%h/%h exp=1/bffc/2222", bus_clint_wr, bus_clint_write_addr, bus_clint_data); end
    tick(); // cycle 6
    checks++; if ({m0_ack, m1_ack} !== 2'b01) begin failures++; $display("FAIL lock_ack2 got=%b exp=01", {m0_ack, m1_ack}); end
    m1_req = 0;
    tick(); tick(); // cycle 8: m0 finally strobes
    checks++; if (bus_clint_wr !== 1'b1 || bus_clint_write_addr !== 16'h0000) begin failures++; $display("FAIL lock_m0 got=%0h/%h exp=1/0000", bus_clint_wr, bus_clint_write_addr); end
    tick();
    m0_req = 0;
    tick();
  endtask

  task automatic test_lock_timeout();
    int idle_bad;
    do_reset();
    m0_req = 1; m0_rd = 1; m0_lock = 1; m0_addr = CLINT_MTIME_ADDR;
    tick(); tick(); // cycle 3: ack
    checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL to_ack0 got=%0h exp=1", m0_ack); end
    m0_req = 0; m1_req = 1; m1_wr = 1; m1_addr = 16'h0004; m1_wdata = 32'h77;
    idle_bad = 0;
    for (int i = 0; i < 17; i++) begin // cycles 4..20 stay idle
      tick();
      if (busy !== 1'b0) idle_bad++;
    end
    checks++; if (idle_bad !== 0) begin failures++; $display("FAIL to_blocked got=%0d busy cycles exp=0", idle_bad); end
    tick(); // cycle 21
    checks++; if ({busy, bus_clint_wr} !== 2'b11) begin failures++; $display("FAIL to_grant got=%b exp=11", {busy, bus_clint_wr}); end
    tick();
    checks++; if (m1_ack !== 1'b1) begin failures++; $display("FAIL to_ack1 got=%0h exp=1", m1_ack); end
    m1_req = 0;
    tick();
  endtask

  task automatic test_rd_wr_combos();
    do_reset();
    m0_req = 1; m0_rd = 1; m0_wr = 1; m0_addr = CLINT_MSIP_ADDR; m0_wdata = 32'h1; clint_bus_data = 32'hDEADBEEF;
    tick(); // cycle 2
    checks++; if ({bus_clint_rd, bus_clint_wr} !== 2'b01 || bus_clint_data !== 32'h1) begin failures++; $display("FAIL rw_strobe got=%b/%h exp=01/1", {bus_clint_rd, bus_clint_wr}, bus_clint_data); end
    tick(); // cycle 3, new request presented during RESP
    checks++; if (m0_ack !== 1'b1 || m0_rdata !== 32'h0) begin failures++; $display("FAIL rw_ack got=%0h/%h exp=1/0", m0_ack, m0_rdata); end
    m0_rd = 0; m0_wr = 0;
    tick(); // cycle 4 IDLE
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL resp_sample got=%0h exp=0", busy); end
    tick(); // cycle 5
    checks++; if ({busy, bus_clint_rd, bus_clint_wr} !== 3'b100) begin failures++; $display("FAIL none_strobe got=%b exp=100", {busy, bus_clint_rd, bus_clint_wr}); end
    tick(); // cycle 6
    checks++; if (m0_ack !== 1'b1 || m0_rdata !== 32'h0) begin failures++; $display("FAIL none_ack got=%0h/%h exp=1/0", m0_ack, m0_rdata); end
    m0_req = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_req = 1; m0_rd = 1; m0_addr = 16'h4004; clint_bus_data = 32'h99;
    tick(); // ACCESS
    checks++; if (bus_clint_rd !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0h exp=1", bus_clint_rd); end
    rst = 1'b0;
    #1;
    checks++; if ({bus_clint_rd, busy} !== 2'b00) begin failures++; $display("FAIL mid_async got=%b exp=00", {bus_clint_rd, busy}); end
    tick();
    checks++; if ({m0_ack, m1_ack} !== 2'b00) begin failures++; $display("FAIL mid_noack got=%b exp=00", {m0_ack, m1_ack}); end
    rst = 1'b1;
    m1_req = 1; m1_wr = 1; m1_addr = 16'h0008;
    tick();
    checks++; if ({bus_clint_rd, bus_clint_wr} !== 2'b10 || bus_clint_read_addr !== 16'h4004) begin failures++; $display("FAIL mid_tie got=%b/%h exp=10/4004", {bus_clint_rd, bus_clint_wr}, bus_clint_read_addr); end
    tick();
    checks++; if ({m0_ack, m1_ack} !== 2'b10 || m0_rdata !== 32'h99) begin failures++; $display("FAIL mid_ack got=%b/%h exp=10/99", {m0_ack, m1_ack}, m0_rdata); end
    m0_req = 0; m1_req = 0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_lock_timeout();
    test_rd_wr_combos();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
